demux_route_buffer: RTL and testbench

- Sits directly downstream of the 16-bit 1x2 demux stage and registers what it produces.
- Accepts one 16-bit word per cycle tagged with a destination select, then queues it into one of two independent per-destination FIFOs.
- Presents each FIFO to its consumer with a valid/ready handshake: channel A when sel=0, channel B when sel=1.
- Decouples the routing point from consumers that stall, e.g. register-file write port vs. output/memory port.

---
 rtl/demux_route_buffer_pkg.sv | 12 +
 rtl/demux_route_buffer_if.sv | 39 +++
 rtl/demux_route_buffer_route_fifo.sv | 54 +++++
 rtl/demux_route_buffer.sv | 87 ++++++++
 tb/tb_demux_route_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/demux_route_buffer_pkg.sv
// Shared definitions for the demux route buffer: default word width and
// the destination select encodings.
package demux_route_buffer_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/demux_route_buffer_if.sv
// Handshake bundle between the demux stage, the route buffer and its two
// downstream consumers.
interface demux_route_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 2
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [CNT_W-1:0] a_count;

  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] b_count;

  logic             drop_err;

  // Upstream producer and downstream consumers
  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, a_count,
           b_data, b_valid, b_count, drop_err
  );

  // The route buffer itself
  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, a_count,
           b_data, b_valid, b_count, drop_err
  );

endinterface

// File: rtl/demux_route_buffer_route_fifo.sv
// Per-destination synchronous FIFO. Head entry is always driven from
// storage[rd_ptr]; storage is cleared on reset so an empty FIFO reads 0.
module route_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/demux_route_buffer.sv
// Route buffer: steers each accepted word into channel A or B FIFO and
// flags upstream changes to in_data/in_sel while stalled.
module demux_route_buffer
  import demux_route_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input logic                  clk,
  input logic                  rst,
  demux_route_buffer_if.slave  bus
);

  sel_e             sel;
  logic             a_full;
  logic             b_full;
  logic             a_empty;
  logic             b_empty;
  logic             ready;
  logic             accept;
  logic             stall;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;
  sel_e             prev_sel;
  logic             drop_q;

  assign sel = sel_e'(bus.in_sel);

  // Ready depends only on registered fullness and the select, never on consumer ready
  always_comb begin
    ready = 1'b0;
    if (!rst) begin
      ready = (sel == SEL_B) ? ~b_full : ~a_full;
    end
  end

  assign bus.in_ready = ready;
  assign accept       = bus.in_valid & ready;
  assign stall        = bus.in_valid & ~ready;
  assign bus.a_valid  = ~a_empty;
  assign bus.b_valid  = ~b_empty;
  assign bus.drop_err = drop_q;

  route_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (accept & (sel == SEL_A)),
    .push_data (bus.in_data),
    .pop       (bus.a_ready),
    .head_data (bus.a_data),
    .count     (bus.a_count),
    .full      (a_full),
    .empty     (a_empty)
  );

  route_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (accept & (sel == SEL_B)),
    .push_data (bus.in_data),
    .pop       (bus.b_ready),
    .head_data (bus.b_data),
    .count     (bus.b_count),
    .full      (b_full),
    .empty     (b_empty)
  );

  // Sticky protocol checker: a word stalled last cycle must be re-presented unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
      prev_data  <= '0;
      prev_sel   <= SEL_A;
      drop_q     <= 1'b0;
    end else begin
      if (prev_stall && bus.in_valid &&
          ((bus.in_data != prev_data) || (sel != prev_sel))) begin
        drop_q <= 1'b1;
      end
      prev_stall <= stall;
      prev_data  <= bus.in_data;
      prev_sel   <= sel;
    end
  end

endmodule

// File: tb/tb_demux_route_buffer.sv
// Directed scoreboard bench for demux_route_buffer.
module tb_demux_route_buffer;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  demux_route_buffer_if #(.WIDTH(16), .CNT_W(2)) bus ();

  demux_route_buffer #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        exp_drop = 1'b0;
  logic        m_stall  = 1'b0;
  logic [15:0] m_data   = '0;
  logic        m_sel    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance model across the edge
  task automatic step();
    logic exp_rdy;
    logic push;
    logic popa;
    logic popb;
    logic viol;
    #1;
    if (rst) exp_rdy = 1'b0;
    else     exp_rdy = bus.in_sel ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("a_count",  bus.a_count,  qa.size());
    chk("b_count",  bus.b_count,  qb.size());
    chk("a_valid",  bus.a_valid,  qa.size() != 0);
    chk("b_valid",  bus.b_valid,  qb.size() != 0);
    chk("drop_err", bus.drop_err, exp_drop);
    if (qa.size() != 0) chk("a_data", bus.a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", bus.b_data, qb[0]);
    push = bus.in_valid & exp_rdy;
    popa = bus.a_ready & (qa.size() != 0);
    popb = bus.b_ready & (qb.size() != 0);
    viol = m_stall & bus.in_valid & ((bus.in_data != m_data) | (bus.in_sel != m_sel));
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      exp_drop = 1'b0;
      m_stall  = 1'b0;
      m_data   = '0;
      m_sel    = 1'b0;
    end else begin
      if (popa) void'(qa.pop_front());
      if (popb) void'(qb.pop_front());
      if (push) begin
        if (bus.in_sel) qb.push_back(bus.in_data);
        else            qa.push_back(bus.in_data);
      end
      if (viol) exp_drop = 1'b1;
      m_stall = bus.in_valid & ~exp_rdy;
      m_data  = bus.in_data;
      m_sel   = bus.in_sel;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    rst          = 1'b1;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    drive(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset then idle
    #1;
    chk("rst_a_data", bus.a_data, 16'h0000);
    chk("rst_b_data", bus.b_data, 16'h0000);
    step();
    drive(1'b0, 1'b1, 16'h0000);
    step();

    // Routing
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    drive(1'b1, 1'b0, 16'hA5A5);
    step();
    drive(1'b1, 1'b1, 16'h5A5A);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    step();
    step();

    // Full / back-pressure
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0001);
    step();
    drive(1'b1, 1'b0, 16'h0002);
    step();
    drive(1'b1, 1'b0, 16'h0003);
    #1;
    chk("full_a_ready", bus.in_ready, 1'b0);
    drive(1'b1, 1'b1, 16'h0BBB);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    step();
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;

    // Full with concurrent pop: push refused, lands next cycle
    bus.a_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h0004);
    step();
    bus.a_ready = 1'b0;
    step();
    drive(1'b0, 1'b0, 16'h0000);
    bus.a_ready = 1'b1;
    step();
    step();
    step();

    // Wrap-around on B
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 16'h0100 + 16'(i));
      step();
      chk("b_count_max", bus.b_count <= 2'd2, 1'b1);
    end
    drive(1'b0, 1'b0, 16'h0000);
    step();
    step();
    bus.b_ready = 1'b0;

    // Reset with two words queued in A
    drive(1'b1, 1'b0, 16'h0AA0);
    step();
    drive(1'b1, 1'b0, 16'h0AA1);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_a_count", bus.a_count, 2'd0);
    chk("mid_rst_a_valid", bus.a_valid, 1'b0);
    step();

    // Protocol violation under stall
    drive(1'b1, 1'b0, 16'h0C00);
    step();
    drive(1'b1, 1'b0, 16'h0C01);
    step();
    drive(1'b1, 1'b0, 16'h1111);
    step();
    drive(1'b1, 1'b0, 16'h2222);
    step();
    #1;
    chk("drop_set", bus.drop_err, 1'b1);
    drive(1'b0, 1'b0, 16'h0000);
    step();
    step();
    chk("drop_sticky", bus.drop_err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("drop_cleared", bus.drop_err, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
